ascon_tag_check: RTL and testbench

Decryption-side tag verifier for the ASCON-AEAD128 core. After finalization, the permutation datapath produces a 128-bit computed tag. This block latches that tag, accepts the received tag as a stream of words over a valid/ready handshake, and compares the two in constant time. It then reports a single authentication verdict. It is the verifying counterpart of tag generation on the encryption side and sits between the finalization stage and the plaintext-release logic.

---
 rtl/ascon_tag_check.sv | 226 ++++++++++++++++++++++
 tb/tb_ascon_tag_check.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_tag_check.sv
// ascon_tag_check
// ----------------------------------------------------------------------------
// Decryption-side tag verifier for ASCON-AEAD128.
//
// Operation:
//   - On start the computed tag is latched.
//   - The received tag is then streamed in, most-significant word first.
//   - Every word is XORed against the matching slice of the latched tag, and
//     the difference is OR-accumulated.
//   - All N = 128/WORD_W words are always consumed, with no early exit, so
//     the time to a verdict does not depend on the data.
//   - The verdict appears in the single RESULT cycle, together with done_o.
//
// Parameters:
//   WORD_W       received-tag word width, 32 or 64
//
// Ports:
//   clock_i      rising-edge clock
//   resetb_i     asynchronous active-low reset
//   start_i      start pulse; tag_calc_i is sampled when it is accepted (IDLE)
//   abort_i      synchronous abort back to IDLE (highest priority)
//   tag_calc_i   128-bit computed tag
//   tag_word_i   received tag word
//   tag_valid_i  tag_word_i valid
//   tag_ready_o  word accepted this cycle when valid (COLLECT)
//   busy_o       high in COLLECT and RESULT
//   done_o       one-cycle verdict strobe
//   auth_ok_o    1 = tags matched; held until the next start or abort
//   fail_cnt_o   saturating count of failed verifications
//
// Optional feature:
//   Defining ASCON_TAG_MISMATCH_CNT_EN builds the failure counter.
//   Without it, fail_cnt_o is tied to zero.
// ----------------------------------------------------------------------------
module ascon_tag_check #(
    parameter int WORD_W = 32
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [127:0]      tag_calc_i,
    input  logic [WORD_W-1:0] tag_word_i,
    input  logic              tag_valid_i,
    output logic              tag_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              auth_ok_o,
    output logic [7:0]        fail_cnt_o
);

    localparam int N     = 128 / WORD_W;
    localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RESULT  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [127:0]       tag_r;
    logic [127:0]       diff_r;
    logic [127:0]       diff_upd_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               auth_ok_r;
    logic               ready_r;
    logic               busy_r;
    logic               done_r;
    logic               ready_nxt_s;
    logic               busy_nxt_s;
    logic               done_nxt_s;
    logic               accept_s;
    logic               last_s;
    logic               start_acc_s;
    logic               verdict_s;

    // A word in the same cycle as abort is never taken.
    assign accept_s    = (state_r == ST_COLLECT) && tag_valid_i && !abort_i;
    assign last_s      = accept_s && (cnt_r == LAST_IDX);
    assign start_acc_s = (state_r == ST_IDLE) && start_i && !abort_i;
    // Verdict includes the final word's contribution (diff_upd_s, not diff_r).
    assign verdict_s   = (diff_upd_s == 128'd0);

    // Difference accumulator: OR the XOR of the current word into slice cnt_r.
    always_comb begin
        diff_upd_s = diff_r;
        for (int k = 0; k < N; k++) begin
            if (cnt_r == CNT_W'(k)) begin
                diff_upd_s[127-k*WORD_W -: WORD_W] = diff_r[127-k*WORD_W -: WORD_W]
                    | (tag_word_i ^ tag_r[127-k*WORD_W -: WORD_W]);
            end else begin
                diff_upd_s[127-k*WORD_W -: WORD_W] = diff_r[127-k*WORD_W -: WORD_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; abort overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        if (abort_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        state_nxt_s = ST_COLLECT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (last_s) begin
                        state_nxt_s = ST_RESULT;
                    end else begin
                        state_nxt_s = ST_COLLECT;
                    end
                end
                ST_RESULT: state_nxt_s = ST_IDLE;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM output decode from the next state, so the flops below present
    // each output in the same cycle as the state it belongs to.
    always_comb begin
        ready_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                ready_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b0;
            end
            ST_COLLECT: begin
                ready_nxt_s = 1'b1;
                busy_nxt_s  = 1'b1;
                done_nxt_s  = 1'b0;
            end
            ST_RESULT: begin
                ready_nxt_s = 1'b0;
                busy_nxt_s  = 1'b1;
                done_nxt_s  = 1'b1;
            end
            default: begin
                ready_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b0;
            end
        endcase
    end

    // Registered handshake/status outputs.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= ready_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Tag latch, difference accumulator, word counter and verdict.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            tag_r     <= 128'd0;
            diff_r    <= 128'd0;
            cnt_r     <= '0;
            auth_ok_r <= 1'b0;
        end else if (abort_i) begin
            diff_r    <= 128'd0;
            cnt_r     <= '0;
            auth_ok_r <= 1'b0;
        end else if (start_acc_s) begin
            tag_r     <= tag_calc_i;
            diff_r    <= 128'd0;
            cnt_r     <= '0;
            auth_ok_r <= 1'b0;
        end else if (accept_s) begin
            diff_r <= diff_upd_s;
            cnt_r  <= cnt_r + CNT_W'(1);
            if (last_s) begin
                auth_ok_r <= verdict_s;
            end
        end
    end

`ifdef ASCON_TAG_MISMATCH_CNT_EN
    logic [7:0] fail_cnt_r;

    // Saturating failure counter, bumped together with a failing verdict.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fail_cnt_r <= 8'h00;
        end else if (last_s && !verdict_s && (fail_cnt_r != 8'hFF)) begin
            fail_cnt_r <= fail_cnt_r + 8'h01;
        end
    end

    assign fail_cnt_o = fail_cnt_r;
`else
    assign fail_cnt_o = 8'h00;
`endif

    assign tag_ready_o = ready_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign auth_ok_o   = auth_ok_r;

endmodule

// File: tb/tb_ascon_tag_check.sv
// Self-checking bench for ascon_tag_check.
// It instantiates a WORD_W=32 and a WORD_W=64 build side by side, which share
// the clock and the reset.
module tb_ascon_tag_check;

    logic         clk;
    logic         resetb;

    logic         start32, abort32, valid32;
    logic [127:0] calc32;
    logic [31:0]  word32;
    logic         ready32, busy32, done32, ok32;
    logic [7:0]   fcnt32;

    logic         start64, abort64, valid64;
    logic [127:0] calc64;
    logic [63:0]  word64;
    logic         ready64, busy64, done64, ok64;
    logic [7:0]   fcnt64;

    int n_vec;
    int n_err;
    int fail_exp32;
    int fail_exp64;

    ascon_tag_check #(.WORD_W(32)) dut32 (
        .clock_i(clk), .resetb_i(resetb), .start_i(start32), .abort_i(abort32),
        .tag_calc_i(calc32), .tag_word_i(word32), .tag_valid_i(valid32),
        .tag_ready_o(ready32), .busy_o(busy32), .done_o(done32),
        .auth_ok_o(ok32), .fail_cnt_o(fcnt32)
    );

    ascon_tag_check #(.WORD_W(64)) dut64 (
        .clock_i(clk), .resetb_i(resetb), .start_i(start64), .abort_i(abort64),
        .tag_calc_i(calc64), .tag_word_i(word64), .tag_valid_i(valid64),
        .tag_ready_o(ready64), .busy_o(busy64), .done_o(done64),
        .auth_ok_o(ok64), .fail_cnt_o(fcnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [127:0] calc;
        logic [127:0] rx;
        logic [15:0]  gaps;     // idle cycles before word k in gaps[4k+:4]
        int           exp_done;
        logic         exp_ok;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int bump(input int c, input logic ok);
`ifdef ASCON_TAG_MISMATCH_CNT_EN
        if (!ok && c < 255) return c + 1;
        return c;
`else
        return 0;
`endif
    endfunction

    // One full WORD_W=32 verification with per-word idle gaps. The verdict
    // is observed in the cycle that follows the last word.
    task automatic verify32(input string nm, input logic [127:0] calc,
                            input logic [127:0] rx, input logic [15:0] gaps,
                            output int done_cyc, output logic ok_seen);
        int cyc;
        done_cyc = -1;
        ok_seen  = 1'b0;
        start32 = 1'b1; calc32 = calc; valid32 = 1'b0;
        tick();
        start32 = 1'b0; calc32 = '0; cyc = 1;
        chk({nm, " ready@1"}, int'(ready32), 1);
        chk({nm, " busy@1"}, int'(busy32), 1);
        chk({nm, " auth cleared"}, int'(ok32), 0);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < int'(gaps[4*k +: 4]); g++) begin
                valid32 = 1'b0; word32 = $urandom;
                chk({nm, " ready stall"}, int'(ready32), 1);
                chk({nm, " no early done"}, int'(done32), 0);
                tick(); cyc++;
            end
            valid32 = 1'b1; word32 = rx[127-32*k -: 32];
            chk({nm, " ready word"}, int'(ready32), 1);
            chk({nm, " no early done"}, int'(done32), 0);
            tick(); cyc++;
        end
        valid32 = 1'b0; word32 = $urandom;
        if (done32) begin
            done_cyc = cyc;
            ok_seen  = ok32;
        end
        chk({nm, " ready in result"}, int'(ready32), 0);
        tick();
        chk({nm, " done one pulse"}, int'(done32), 0);
        chk({nm, " busy after"}, int'(busy32), 0);
    endtask

    vec_t         tbl[3];
    logic [127:0] t0;
    logic [127:0] rnd_calc;
    logic [127:0] rnd_rx;
    logic [15:0]  rnd_gaps;
    int           dcyc;
    int           exp_d;
    logic         okv;
    logic         exp_ok;

    initial begin
        n_vec = 0; n_err = 0; fail_exp32 = 0; fail_exp64 = 0;
        start32 = 0; abort32 = 0; valid32 = 0; calc32 = '0; word32 = '0;
        start64 = 0; abort64 = 0; valid64 = 0; calc64 = '0; word64 = '0;
        t0 = 128'h4f9c2782_11bec931_6bf68f46_ee8b2ec6;

        resetb = 1'b0;
        #12;
        chk("reset ready", int'(ready32), 0);
        chk("reset busy", int'(busy32), 0);
        chk("reset done", int'(done32), 0);
        chk("reset auth", int'(ok32), 0);
        chk("reset fail_cnt", int'(fcnt32), 0);
        chk("reset64 ready", int'(ready64), 0);
        tick();
        resetb = 1'b1;
        tick();

        // Directed table
        tbl[0] = '{"match32", t0, t0, 16'h0000, 5, 1'b1};
        tbl[1] = '{"lastbit", t0, t0 ^ 128'd1, 16'h0000, 5, 1'b0};
        tbl[2] = '{"early_stall", t0, {32'h0, t0[95:0]}, 16'h2220, 11, 1'b0};
        for (int i = 0; i < 3; i++) begin
            verify32(tbl[i].name, tbl[i].calc, tbl[i].rx, tbl[i].gaps, dcyc, okv);
            fail_exp32 = bump(fail_exp32, tbl[i].exp_ok);
            chk({tbl[i].name, " done cycle"}, dcyc, tbl[i].exp_done);
            chk({tbl[i].name, " auth@done"}, int'(okv), int'(tbl[i].exp_ok));
            tick(); tick(); tick();
            chk({tbl[i].name, " auth held"}, int'(ok32), int'(tbl[i].exp_ok));
            chk({tbl[i].name, " fail_cnt"}, int'(fcnt32), fail_exp32);
        end

        // A passing result, then abort in IDLE clears the verdict.
        verify32("pre_abort", t0, t0, 16'h0000, dcyc, okv);
        chk("pre_abort auth", int'(ok32), 1);
        abort32 = 1'b1; tick(); abort32 = 1'b0;
        chk("idle abort clears auth", int'(ok32), 0);

        // Abort after two words; the word offered with abort is not taken.
        start32 = 1'b1; calc32 = t0; tick(); start32 = 1'b0;
        valid32 = 1'b1; word32 = t0[127:96]; tick();
        word32 = 32'hdead_beef; tick();
        abort32 = 1'b1; word32 = t0[63:32]; tick();
        abort32 = 1'b0; valid32 = 1'b0;
        chk("abort ready", int'(ready32), 0);
        chk("abort busy", int'(busy32), 0);
        for (int c = 0; c < 6; c++) begin
            chk("abort no done", int'(done32), 0);
            tick();
        end
        chk("abort fail_cnt", int'(fcnt32), fail_exp32);
        verify32("post_abort", t0, t0, 16'h0000, dcyc, okv);
        chk("post_abort done", dcyc, 5);
        chk("post_abort auth", int'(okv), 1);

        // Abort coincident with the final word.
        start32 = 1'b1; calc32 = t0; tick(); start32 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid32 = 1'b1; word32 = t0[127-32*k -: 32]; tick();
        end
        abort32 = 1'b1; word32 = t0[31:0]; tick();
        abort32 = 1'b0; valid32 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("last-word abort no done", int'(done32), 0);
            chk("last-word abort auth", int'(ok32), 0);
            tick();
        end

        // WORD_W=64: start pulses inside COLLECT must be ignored.
        start64 = 1'b1; calc64 = t0; tick(); start64 = 1'b0;
        chk("w64 ready@1", int'(ready64), 1);
        valid64 = 1'b1; word64 = t0[127:64]; start64 = 1'b1; calc64 = ~t0; tick();
        chk("w64 ready@2", int'(ready64), 1);
        chk("w64 no done@2", int'(done64), 0);
        word64 = t0[63:0]; tick();
        start64 = 1'b0; valid64 = 1'b0;
        chk("w64 done@3", int'(done64), 1);
        chk("w64 auth@3", int'(ok64), 1);
        tick();
        chk("w64 done pulse", int'(done64), 0);
        chk("w64 busy idle", int'(busy64), 0);
        start64 = 1'b1; calc64 = t0; tick(); start64 = 1'b0;
        valid64 = 1'b1; word64 = t0[127:64]; tick();
        word64 = t0[63:0] ^ 64'h8000_0000_0000_0000; tick();
        valid64 = 1'b0;
        fail_exp64 = bump(fail_exp64, 1'b0);
        chk("w64 mismatch done", int'(done64), 1);
        chk("w64 mismatch auth", int'(ok64), 0);
        tick();
        chk("w64 fail_cnt", int'(fcnt64), fail_exp64);

        // Randomized runs against the abstract model: the verdict is tag
        // equality, and the latency is one cycle per word plus the stalls.
        for (int r = 0; r < 40; r++) begin
            rnd_calc = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       rnd_rx = rnd_calc;
                1:       rnd_rx = rnd_calc ^ (128'd1 << $urandom_range(0, 127));
                default: rnd_rx = {$urandom, $urandom, $urandom, $urandom};
            endcase
            rnd_gaps = 16'h0;
            exp_d = 5;
            for (int k = 0; k < 4; k++) begin
                rnd_gaps[4*k +: 4] = 4'($urandom_range(0, 3));
                exp_d += int'(rnd_gaps[4*k +: 4]);
            end
            exp_ok = (rnd_rx == rnd_calc);
            verify32("rand", rnd_calc, rnd_rx, rnd_gaps, dcyc, okv);
            fail_exp32 = bump(fail_exp32, exp_ok);
            chk("rand done cycle", dcyc, exp_d);
            chk("rand auth", int'(okv), int'(exp_ok));
            chk("rand fail_cnt", int'(fcnt32), fail_exp32);
        end

        // Saturation: 260 failing runs.
        for (int r = 0; r < 260; r++) begin
            verify32("sat", t0, ~t0, 16'h0000, dcyc, okv);
            fail_exp32 = bump(fail_exp32, 1'b0);
        end
`ifdef ASCON_TAG_MISMATCH_CNT_EN
        chk("sat fail_cnt FF", int'(fcnt32), 255);
`else
        chk("sat fail_cnt tied 0", int'(fcnt32), 0);
`endif
        chk("sat model", int'(fcnt32), fail_exp32);
        tick(); tick();
        chk("sat held", int'(fcnt32), fail_exp32);
        resetb = 1'b0;
        #2;
        chk("reset clears fail_cnt", int'(fcnt32), 0);
        tick();
        resetb = 1'b1;
        tick();
        verify32("after_reset", t0, t0, 16'h0000, dcyc, okv);
        chk("after_reset auth", int'(okv), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
